// File: rtl/alu_sevenseg_display.sv
// Captures an ALU result and shows it on a 4-digit multiplexed seven-segment display.
// Decimal mode uses a sequential shift-add-3 BCD converter; hex mode shows raw nibbles.
module alu_sevenseg_display #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CLK_HZ     = 100000000,
  parameter int unsigned REFRESH_HZ = 1000
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] result,
  input  logic                  signed_mode,
  input  logic                  hex_mode,
  output logic                  busy,
  output logic [3:0]            an,
  output logic [6:0]            seg,
  output logic                  dp
);

  localparam int unsigned TICK_DIV = CLK_HZ / (4 * REFRESH_HZ);
  localparam int unsigned PRE_W    = $clog2(TICK_DIV);
  localparam int unsigned CNT_W    = 3;
  localparam int unsigned BCD_W    = 12;

  // Display character codes: 0..15 are hex digits, plus blank and minus.
  localparam logic [4:0] CH_BLANK = 5'h10;
  localparam logic [4:0] CH_MINUS = 5'h11;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_CONV   = 2'd1;
  localparam logic [1:0] S_COMMIT = 2'd2;

  logic [1:0]            state_q, state_d;
  logic                  busy_q, busy_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] mag_q, mag_d;
  logic [BCD_W-1:0]      bcd_q, bcd_d;
  logic                  neg_q, neg_d;
  logic [DATA_WIDTH-1:0] cap_q, cap_d;
  logic                  pend_q, pend_d;
  logic [3:0][4:0]       dig_q, dig_d;
  logic [PRE_W-1:0]      presc_q, presc_d;
  logic [1:0]            idx_q, idx_d;

  logic [BCD_W-1:0]      bcd_adj;
  logic [7:0]            hex8;
  logic                  neg_c;
  logic [4:0]            sel;

  // Next-state logic for capture, conversion and scan.
  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    cnt_d   = cnt_q;
    mag_d   = mag_q;
    bcd_d   = bcd_q;
    neg_d   = neg_q;
    cap_d   = cap_q;
    pend_d  = pend_q;
    dig_d   = dig_q;
    presc_d = presc_q;
    idx_d   = idx_q;
    bcd_adj = bcd_q;
    hex8    = 8'(cap_q);
    neg_c   = signed_mode & result[DATA_WIDTH-1];

    if (presc_q == PRE_W'(TICK_DIV - 1)) begin
      presc_d = '0;
      idx_d   = idx_q + 2'd1;
    end else begin
      presc_d = presc_q + PRE_W'(1);
    end

    for (int i = 0; i < 3; i++) begin
      if (bcd_q[i*4 +: 4] >= 4'd5) bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
    end

    case (state_q)
      S_IDLE: begin
        if (pend_q) begin
          dig_d  = {CH_BLANK, CH_BLANK,
                    (DATA_WIDTH > 4) ? {1'b0, hex8[7:4]} : CH_BLANK,
                    {1'b0, hex8[3:0]}};
          pend_d = 1'b0;
        end
        if (load) begin
          if (hex_mode) begin
            cap_d  = result;
            pend_d = 1'b1;
          end else begin
            // W-bit negation is enough: the most negative value's magnitude fits unsigned.
            mag_d   = neg_c ? (~result + DATA_WIDTH'(1)) : result;
            neg_d   = neg_c;
            bcd_d   = '0;
            cnt_d   = '0;
            busy_d  = 1'b1;
            state_d = S_CONV;
          end
        end
      end
      S_CONV: begin
        bcd_d = BCD_W'({bcd_adj, mag_q[DATA_WIDTH-1]});
        mag_d = mag_q << 1;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(DATA_WIDTH - 1)) state_d = S_COMMIT;
      end
      S_COMMIT: begin
        dig_d[0] = {1'b0, bcd_q[3:0]};
        dig_d[1] = (bcd_q[11:4] == 8'd0) ? CH_BLANK : {1'b0, bcd_q[7:4]};
        dig_d[2] = (bcd_q[11:8] == 4'd0) ? CH_BLANK : {1'b0, bcd_q[11:8]};
        dig_d[3] = neg_q ? CH_MINUS : CH_BLANK;
        busy_d   = 1'b0;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
      mag_q   <= '0;
      bcd_q   <= '0;
      neg_q   <= 1'b0;
      cap_q   <= '0;
      pend_q  <= 1'b0;
      dig_q   <= {CH_BLANK, CH_BLANK, CH_BLANK, 5'h00};
      presc_q <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
      mag_q   <= mag_d;
      bcd_q   <= bcd_d;
      neg_q   <= neg_d;
      cap_q   <= cap_d;
      pend_q  <= pend_d;
      dig_q   <= dig_d;
      presc_q <= presc_d;
      idx_q   <= idx_d;
    end
  end

  // Digit select and active-low segment decode.
  always_comb begin
    sel = dig_q[idx_q];
    an  = (sel == CH_BLANK) ? 4'b1111 : ~(4'b0001 << idx_q);
    case (sel)
      5'h00:   seg = 7'b1000000;
      5'h01:   seg = 7'b1111001;
      5'h02:   seg = 7'b0100100;
      5'h03:   seg = 7'b0110000;
      5'h04:   seg = 7'b0011001;
      5'h05:   seg = 7'b0010010;
      5'h06:   seg = 7'b0000010;
      5'h07:   seg = 7'b1111000;
      5'h08:   seg = 7'b0000000;
      5'h09:   seg = 7'b0010000;
      5'h0A:   seg = 7'b0001000;
      5'h0B:   seg = 7'b0000011;
      5'h0C:   seg = 7'b1000110;
      5'h0D:   seg = 7'b0100001;
      5'h0E:   seg = 7'b0000110;
      5'h0F:   seg = 7'b0001110;
      CH_MINUS: seg = 7'b0111111;
      default: seg = 7'b1111111;
    endcase
  end

  assign busy = busy_q;
  assign dp   = 1'b1;

endmodule

// File: tb/tb_alu_sevenseg_display.sv
// Directed and random checks of alu_sevenseg_display against an arithmetic display model.
module tb_alu_sevenseg_display;

  localparam int W = 8;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       load;
  logic [7:0] result;
  logic       signed_mode;
  logic       hex_mode;
  logic       busy;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  int vectors     = 0;
  int miscompares = 0;
  int edge_cnt    = 0;
  int exp_dig[4];
  bit exp_busy    = 1'b0;
  bit in_reset    = 1'b1;

  always #5 clk = ~clk;

  alu_sevenseg_display #(.DATA_WIDTH(8), .CLK_HZ(400), .REFRESH_HZ(25)) dut (
    .clk(clk), .reset_n(reset_n), .load(load), .result(result),
    .signed_mode(signed_mode), .hex_mode(hex_mode), .busy(busy),
    .an(an), .seg(seg), .dp(dp)
  );

  // Character codes in the model: 0..15 digits, 16 blank, 17 minus.
  function automatic logic [6:0] seg_of(input int c);
    case (c)
      0:  return 7'b1000000;  1:  return 7'b1111001;
      2:  return 7'b0100100;  3:  return 7'b0110000;
      4:  return 7'b0011001;  5:  return 7'b0010010;
      6:  return 7'b0000010;  7:  return 7'b1111000;
      8:  return 7'b0000000;  9:  return 7'b0010000;
      10: return 7'b0001000;  11: return 7'b0000011;
      12: return 7'b1000110;  13: return 7'b0100001;
      14: return 7'b0000110;  15: return 7'b0001110;
      17: return 7'b0111111;
      default: return 7'b1111111;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp_v);
    end
  endtask

  task automatic check_all(input string tag);
    int         idx;
    logic [3:0] ea;
    idx = in_reset ? 0 : (edge_cnt / 4) % 4;
    ea  = 4'b1111;
    if (exp_dig[idx] != 16) ea[idx] = 1'b0;
    chk({tag, "_busy"}, 7'(busy), 7'(exp_busy));
    chk({tag, "_an"}, 7'(an), 7'(ea));
    chk({tag, "_dp"}, 7'(dp), 7'd1);
    if (exp_dig[idx] != 16) chk({tag, "_seg"}, seg, seg_of(exp_dig[idx]));
  endtask

  task automatic tick();
    @(posedge clk);
    edge_cnt++;
    @(negedge clk);
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      tick();
      check_all(tag);
    end
  endtask

  task automatic model_reset();
    exp_dig[0] = 0; exp_dig[1] = 16; exp_dig[2] = 16; exp_dig[3] = 16;
    exp_busy   = 1'b0;
  endtask

  task automatic model_dec(input int v, input bit sgn);
    bit neg;
    int mag;
    neg = sgn && (v >= 128);
    mag = neg ? 256 - v : v;
    exp_dig[0] = mag % 10;
    exp_dig[1] = (mag < 10)  ? 16 : (mag / 10) % 10;
    exp_dig[2] = (mag < 100) ? 16 : mag / 100;
    exp_dig[3] = neg ? 17 : 16;
  endtask

  task automatic do_dec(input int v, input bit sgn, input int inj_k, input int inj_v);
    result = 8'(v); signed_mode = sgn; hex_mode = 1'b0; load = 1'b1;
    tick();
    load     = 1'b0;
    result   = 8'($urandom_range(0, 255));
    exp_busy = 1'b1;
    for (int k = 0; k <= W; k++) begin
      check_all("dec_run");
      if (k == inj_k) begin
        result = 8'(inj_v); load = 1'b1;
      end
      tick();
      load = 1'b0;
    end
    model_dec(v, sgn);
    exp_busy = 1'b0;
    check_all("dec_done");
  endtask

  task automatic do_hex(input int v);
    result = 8'(v); hex_mode = 1'b1; signed_mode = 1'($urandom_range(0, 1)); load = 1'b1;
    tick();
    load   = 1'b0;
    result = 8'($urandom_range(0, 255));
    check_all("hex_cap");
    tick();
    exp_dig[0] = v % 16; exp_dig[1] = v / 16; exp_dig[2] = 16; exp_dig[3] = 16;
    check_all("hex_done");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0; load = 1'b0; result = '0; signed_mode = 1'b0; hex_mode = 1'b0;
    model_reset();
    in_reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_all("rst");
    end
    reset_n = 1'b1; in_reset = 1'b0; edge_cnt = 0;
    check_all("rst_rel");
    idle(16, "scan_rst");

    do_dec(255, 1'b0, -1, 0);
    idle(16, "scan_255");
    do_dec(8'hFF, 1'b1, -1, 0);
    idle(16, "scan_m1");
    do_dec(8'h80, 1'b1, -1, 0);
    idle(16, "scan_m128");
    do_hex(8'hA5);
    idle(16, "scan_a5");
    do_dec(200, 1'b0, 3, 7);
    idle(16, "scan_200");
    do_dec(0, 1'b1, -1, 0);
    idle(16, "scan_0");

    // Asynchronous reset in the middle of a conversion.
    result = 8'd123; signed_mode = 1'b0; hex_mode = 1'b0; load = 1'b1;
    tick();
    load = 1'b0;
    tick();
    tick();
    reset_n = 1'b0;
    #1;
    in_reset = 1'b1;
    model_reset();
    check_all("midrst");
    tick();
    check_all("midrst_hold");
    reset_n = 1'b1; in_reset = 1'b0; edge_cnt = 0;
    idle(16, "after_midrst");

    for (int n = 0; n < 30; n++) begin
      int v;
      int mode;
      v    = int'($urandom_range(0, 255));
      mode = int'($urandom_range(0, 2));
      if (mode == 2) do_hex(v);
      else           do_dec(v, 1'(mode), -1, 0);
      idle(int'($urandom_range(0, 6)), "rnd_idle");
    end
    idle(16, "final_scan");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
